// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS controller.
//   - FSM state encodings (also visible on the debug `state` port)
//   - opcode / funct constants of the supported instruction subset
//   - datapath select codes (alu_op, reg_dst, mem_to_reg, npc_sel)
//   - instruction class produced by mc_decode and consumed by mc_ctrl
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_LINK  = 2'd2;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JT   = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI,
    C_LW, C_SW, C_BEQ, C_J, C_JAL
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   op_i     [5:0]  IR[31:26]
//   funct_i  [5:0]  IR[5:0]
//   iclass_o        instruction class (C_ILL when unsupported)
//   legal_o         1 when the instruction is in the supported set
//   ext_op_o        1 = sign-extend immediate (lw, sw, beq)
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    iclass_o,
  output logic       legal_o,
  output logic       ext_op_o
);

  always_comb begin
    iclass_o = C_ILL;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          // sll is only used as nop; it runs through the addu path
          FN_SLL, FN_ADDU: iclass_o = C_ADDU;
          FN_SUBU:         iclass_o = C_SUBU;
          FN_JR:           iclass_o = C_JR;
          default:         iclass_o = C_ILL;
        endcase
      end
      OP_ORI:  iclass_o = C_ORI;
      OP_LUI:  iclass_o = C_LUI;
      OP_LW:   iclass_o = C_LW;
      OP_SW:   iclass_o = C_SW;
      OP_BEQ:  iclass_o = C_BEQ;
      OP_J:    iclass_o = C_J;
      OP_JAL:  iclass_o = C_JAL;
      default: iclass_o = C_ILL;
    endcase
  end

  assign legal_o  = (iclass_o != C_ILL);
  assign ext_op_o = (iclass_o == C_LW) || (iclass_o == C_SW) || (iclass_o == C_BEQ);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS datapath.
// Optional feature macro: MC_CTRL_PERF_EN (cycle / retired-instruction counters).
// Ports:
//   clk, reset (async, active low)
//   op, funct, zero, mem_ready                      : inputs from IR / ALU / memory
//   mem_req, mem_we, pc_we, ir_we, reg_we           : datapath enables
//   reg_dst, ExtOp, alu_src, alu_op, mem_to_reg,
//   npc_sel                                         : datapath selects
//   state, trap                                     : debug state, sticky error
//   cycle_cnt, instret_cnt                          : perf counters (0 without macro)
//
// state  | meaning
// IDLE   | after reset, all outputs 0
// FETCH  | instruction read, wait for mem_ready
// DECODE | register read, legality check
// EXEC   | ALU op, branches and jumps complete here
// MEM    | lw/sw data access, wait for mem_ready
// WB     | register-file write
// TRAP   | illegal instruction or bus timeout, held until reset
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic        ExtOp,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  npc_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [7:0] WAIT_LD = 8'(WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  iclass_t    iclass;
  logic       legal;
  logic       ext;
  logic [2:0] alu_op_c;
  logic       alu_src_c;
  logic       wait_tc;

  mc_decode u_decode (
    .op_i     (op),
    .funct_i  (funct),
    .iclass_o (iclass),
    .legal_o  (legal),
    .ext_op_o (ext)
  );

  always_comb begin
    alu_op_c  = ALU_ADD;
    alu_src_c = 1'b0;
    case (iclass)
      C_SUBU, C_BEQ: alu_op_c = ALU_SUB;
      C_ORI:   begin alu_op_c = ALU_OR;  alu_src_c = 1'b1; end
      C_LUI:   begin alu_op_c = ALU_LUI; alu_src_c = 1'b1; end
      C_LW, C_SW: alu_src_c = 1'b1;
      default: ;
    endcase
  end

  // Down-counter reloaded whenever memory is not being waited on; the
  // WAIT_MAX-th consecutive wait cycle is the terminal count.
  assign wait_tc = (wait_q == 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= WAIT_LD;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = WAIT_LD;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    ExtOp      = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = WD_ALU;
    npc_sel    = NPC_PC4;
    trap       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_tc) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_DECODE: begin
        ExtOp   = ext;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        ExtOp   = ext;
        alu_op  = alu_op_c;
        alu_src = alu_src_c;
        case (iclass)
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ: begin
            npc_sel = NPC_BR;
            pc_we   = zero;
            state_d = S_FETCH;
          end
          C_J: begin
            npc_sel = NPC_JT;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL: begin
            npc_sel    = NPC_JT;
            pc_we      = 1'b1;
            reg_we     = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = WD_LINK;
            state_d    = S_FETCH;
          end
          C_JR: begin
            npc_sel = NPC_RS;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        ExtOp   = ext;
        alu_op  = alu_op_c;
        alu_src = alu_src_c;
        mem_req = 1'b1;
        mem_we  = (iclass == C_SW);
        if (mem_ready) begin
          state_d = (iclass == C_SW) ? S_FETCH : S_WB;
        end else if (wait_tc) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_WB: begin
        ExtOp   = ext;
        alu_op  = alu_op_c;
        alu_src = alu_src_c;
        reg_we  = 1'b1;
        case (iclass)
          C_ADDU, C_SUBU: reg_dst = RD_RD;
          C_LW:           mem_to_reg = WD_MEM;
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP)
        cycle_q <= cycle_q + 32'd1;
      if (state_d == S_FETCH &&
          (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, pc_we, ir_we, reg_we, ExtOp, alu_src, trap;
  logic [1:0]  reg_dst, mem_to_reg, npc_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_ctrl #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
    .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst), .ExtOp(ExtOp),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .npc_sel(npc_sel), .state(state), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // Expected behaviour of each supported instruction, straight from the
  // instruction-level description (kind: 0 = ALU, 1 = branch, 2 = jump).
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    int         kind;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] npc;
    logic       ext;
    logic       link;
    logic       has_mem;
    logic       is_sw;
    logic       has_wb;
    logic [1:0] wb_dst;
    logic [1:0] wb_m2r;
  } vec_t;

  vec_t tbl[11];

  int n_pass = 0;
  int n_tot  = 0;

  logic [2:0]  prev_st;
  int unsigned exp_cyc, exp_ret;

  function automatic vec_t mk(string n, logic [5:0] o, logic [5:0] f, int k,
                              logic [2:0] ao, logic as, logic [1:0] np, logic ex,
                              logic lk, logic hm, logic sw, logic hw,
                              logic [1:0] dst, logic [1:0] m2r);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.kind = k; v.alu_op = ao; v.alu_src = as;
    v.npc = np; v.ext = ex; v.link = lk; v.has_mem = hm; v.is_sw = sw;
    v.has_wb = hw; v.wb_dst = dst; v.wb_m2r = m2r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({mem_req, mem_we, pc_we, ir_we, reg_we, reg_dst, ExtOp, alu_src,
                alu_op, mem_to_reg, npc_sel, trap});
  endfunction

  // One clock: drive inputs just after the edge, sample 1 ns later.
  task automatic cyc(input logic [2:0] est, input logic rdy, input logic [5:0] o,
                     input logic [5:0] f, input logic z);
    @(posedge clk);
    #1;
    op = o; funct = f; zero = z; mem_ready = rdy;
    if (prev_st != ST_IDLE && prev_st != ST_TRAP) exp_cyc++;
    if (est == ST_FETCH && (prev_st == ST_EXEC || prev_st == ST_MEM || prev_st == ST_WB))
      exp_ret++;
    prev_st = est;
    #1;
    chk("state", 32'(state), 32'(est));
`ifdef MC_CTRL_PERF_EN
    chk("cycle_cnt", cycle_cnt, exp_cyc);
    chk("instret_cnt", instret_cnt, exp_ret);
`else
    chk("cycle_cnt", cycle_cnt, 32'd0);
    chk("instret_cnt", instret_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset state", 32'(state), 32'(ST_IDLE));
    chk("reset outputs", all_outs(), 32'd0);
    chk("reset cycle_cnt", cycle_cnt, 32'd0);
    chk("reset instret_cnt", instret_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    prev_st = ST_IDLE;
    exp_cyc = 0;
    exp_ret = 0;
    #1;
    chk("idle after release", 32'(state), 32'(ST_IDLE));
    chk("idle outputs", all_outs(), 32'd0);
  endtask

  // Runs one instruction starting from the cycle that should be FETCH.
  task automatic run_instr(input int idx, input int wf, input int wm, input logic z);
    vec_t e;
    e = tbl[idx];
    for (int i = 0; i <= wf; i++) begin
      cyc(ST_FETCH, (i == wf), 6'($urandom), 6'($urandom), z);
      chk({e.name, " fetch mem_req"}, 32'(mem_req), 32'd1);
      chk({e.name, " fetch mem_we"}, 32'(mem_we), 32'd0);
      chk({e.name, " fetch ir_we"}, 32'(ir_we), 32'(i == wf));
      chk({e.name, " fetch pc_we"}, 32'(pc_we), 32'(i == wf));
      if (i == wf) chk({e.name, " fetch npc_sel"}, 32'(npc_sel), 32'd0);
    end
    cyc(ST_DECODE, 1'($urandom), e.op, e.funct, z);
    chk({e.name, " decode ExtOp"}, 32'(ExtOp), 32'(e.ext));
    chk({e.name, " decode enables"}, 32'({mem_req, pc_we, reg_we, ir_we, trap}), 32'd0);
    cyc(ST_EXEC, 1'($urandom), e.op, e.funct, z);
    chk({e.name, " exec ExtOp"}, 32'(ExtOp), 32'(e.ext));
    chk({e.name, " exec mem_req"}, 32'(mem_req), 32'd0);
    case (e.kind)
      0: begin
        chk({e.name, " exec alu_op"}, 32'(alu_op), 32'(e.alu_op));
        chk({e.name, " exec alu_src"}, 32'(alu_src), 32'(e.alu_src));
        chk({e.name, " exec pc_we/reg_we"}, 32'({pc_we, reg_we}), 32'd0);
      end
      1: begin
        chk({e.name, " exec alu_op"}, 32'(alu_op), 32'(e.alu_op));
        chk({e.name, " exec npc_sel"}, 32'(npc_sel), 32'(e.npc));
        chk({e.name, " exec pc_we"}, 32'(pc_we), 32'(z));
      end
      default: begin
        chk({e.name, " exec npc_sel"}, 32'(npc_sel), 32'(e.npc));
        chk({e.name, " exec pc_we"}, 32'(pc_we), 32'd1);
        chk({e.name, " exec reg_we"}, 32'(reg_we), 32'(e.link));
        if (e.link) chk({e.name, " exec link sel"}, 32'({reg_dst, mem_to_reg}), 32'({2'd2, 2'd2}));
      end
    endcase
    if (e.has_mem) begin
      for (int i = 0; i <= wm; i++) begin
        cyc(ST_MEM, (i == wm), e.op, e.funct, z);
        chk({e.name, " mem mem_req"}, 32'(mem_req), 32'd1);
        chk({e.name, " mem mem_we"}, 32'(mem_we), 32'(e.is_sw));
        chk({e.name, " mem pc_we/reg_we"}, 32'({pc_we, reg_we}), 32'd0);
      end
    end
    if (e.has_wb) begin
      cyc(ST_WB, 1'($urandom), e.op, e.funct, z);
      chk({e.name, " wb reg_we"}, 32'(reg_we), 32'd1);
      chk({e.name, " wb reg_dst"}, 32'(reg_dst), 32'(e.wb_dst));
      chk({e.name, " wb mem_to_reg"}, 32'(mem_to_reg), 32'(e.wb_m2r));
      chk({e.name, " wb pc_we/mem_req"}, 32'({pc_we, mem_req}), 32'd0);
    end
  endtask

  task automatic illegal_seq(input logic [5:0] o, input logic [5:0] f);
    cyc(ST_FETCH, 1'b1, 6'($urandom), 6'($urandom), 1'b0);
    cyc(ST_DECODE, 1'($urandom), o, f, 1'b0);
    chk("illegal decode trap", 32'(trap), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(ST_TRAP, 1'($urandom), o, f, 1'($urandom));
      chk("illegal trap flag", 32'(trap), 32'd1);
      chk("illegal enables", 32'({pc_we, reg_we, mem_req, ir_we, mem_we}), 32'd0);
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int idx, wf, wm;
    //           name    op     funct  k  alu  src npc ext lnk mem sw  wb  dst  m2r
    tbl[0]  = mk("addu", 6'h00, 6'h21, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0);
    tbl[1]  = mk("subu", 6'h00, 6'h23, 0, 3'd1, 0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0);
    tbl[2]  = mk("nop",  6'h00, 6'h00, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0);
    tbl[3]  = mk("jr",   6'h00, 6'h08, 2, 3'd0, 0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    tbl[4]  = mk("ori",  6'h0D, 6'h3F, 0, 3'd2, 1, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
    tbl[5]  = mk("lui",  6'h0F, 6'h12, 0, 3'd3, 1, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0);
    tbl[6]  = mk("lw",   6'h23, 6'h00, 0, 3'd0, 1, 2'd0, 1, 0, 1, 0, 1, 2'd0, 2'd1);
    tbl[7]  = mk("sw",   6'h2B, 6'h00, 0, 3'd0, 1, 2'd0, 1, 0, 1, 1, 0, 2'd0, 2'd0);
    tbl[8]  = mk("beq",  6'h04, 6'h00, 1, 3'd1, 0, 2'd1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    tbl[9]  = mk("j",    6'h02, 6'h00, 2, 3'd0, 0, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    tbl[10] = mk("jal",  6'h03, 6'h00, 2, 3'd0, 0, 2'd2, 0, 1, 0, 0, 0, 2'd0, 2'd0);

    reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    prev_st = ST_IDLE; exp_cyc = 0; exp_ret = 0;
    @(posedge clk);
    #2;
    do_reset();

    // every instruction once, zero-wait memory
    for (int i = 0; i < 11; i++) run_instr(i, 0, 0, 1'b0);
    run_instr(8, 0, 0, 1'b1);           // beq taken
    run_instr(6, 0, 3, 1'b0);           // lw, 3 MEM wait cycles
    run_instr(7, 14, 14, 1'b0);         // longest legal waits

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 10);
      wf  = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      wm  = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      run_instr(idx, wf, wm, 1'($urandom));
    end

    illegal_seq(6'h3F, 6'h00);
    illegal_seq(6'h00, 6'h2A);

    // fetch timeout: 15 wait cycles then TRAP
    for (int i = 0; i < 15; i++) begin
      cyc(ST_FETCH, 1'b0, 6'($urandom), 6'($urandom), 1'b0);
      chk("fetch timeout mem_req held", 32'(mem_req), 32'd1);
      chk("fetch timeout ir_we", 32'(ir_we), 32'd0);
    end
    cyc(ST_TRAP, 1'b1, 6'h00, 6'h21, 1'b0);
    chk("fetch timeout trap", 32'(trap), 32'd1);
    chk("fetch timeout mem_req", 32'(mem_req), 32'd0);
    do_reset();

    // memory-stage timeout on sw
    cyc(ST_FETCH, 1'b1, 6'h2B, 6'h00, 1'b0);
    cyc(ST_DECODE, 1'b0, 6'h2B, 6'h00, 1'b0);
    cyc(ST_EXEC, 1'b0, 6'h2B, 6'h00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc(ST_MEM, 1'b0, 6'h2B, 6'h00, 1'b0);
      chk("mem timeout req/we held", 32'({mem_req, mem_we}), 32'd3);
    end
    cyc(ST_TRAP, 1'b1, 6'h2B, 6'h00, 1'b0);
    chk("mem timeout trap", 32'(trap), 32'd1);
    do_reset();

    // reset in the middle of a fetch wait
    run_instr(0, 0, 0, 1'b0);
    cyc(ST_FETCH, 1'b0, 6'h00, 6'h21, 1'b0);
    cyc(ST_FETCH, 1'b0, 6'h00, 6'h21, 1'b0);
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    #2;
    do_reset();
    run_instr(6, 1, 0, 1'b0);
    run_instr(0, 0, 0, 1'b0);
    cyc(ST_FETCH, 1'b0, 6'h00, 6'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
